// File: rtl/video_pkg.sv
// Shared types for the gray-ramp video pattern checker.
package video_pkg;

  localparam int CNT_W   = 16;  // x/y counter and geometry width
  localparam int PIX_W   = 8;   // colour component width
  localparam int SUM_LAT = 2;   // cycles from frame edge to frame summary

  // Checker frame-tracking state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the first frame edge
    ST_FIRST = 2'd1,  // first frame, no seed history yet
    ST_RUN   = 2'd2   // full checking including seed advance
  } chk_state_t;

  // Per-frame summary as seen by the timing measurement
  typedef struct packed {
    logic [CNT_W-1:0] hactive;
    logic [CNT_W-1:0] vactive;
    logic             ok;
  } frame_stat_t;

  // Ramp law: every component of pixel (x,y) equals (x+y+seed) mod 256
  function automatic logic [PIX_W-1:0] ramp_val(input logic [PIX_W-1:0] x,
                                                input logic [PIX_W-1:0] y,
                                                input logic [PIX_W-1:0] seed);
    return x + y + seed;
  endfunction

endpackage

// File: rtl/video_timing_meas.sv
// Frame/line edge detection, pixel coordinates and active-geometry measurement.
module video_timing_meas
  import video_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             vs,
  input  logic             de,
  output logic             frame_edge,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output frame_stat_t      last_frame
);

  logic             vs_q;
  logic             de_q;
  logic             de_fall;
  logic [CNT_W-1:0] line_len;    // de-high cycles seen so far in the current line
  logic [CNT_W-1:0] y_cnt;       // completed lines in the current frame
  logic [CNT_W-1:0] href;        // first line's length, reference for the frame
  logic             first_done;  // href is valid
  logic             geom_err;
  logic             any_de;

  assign frame_edge = (vs == VS_POL) && (vs_q != VS_POL);
  assign de_fall    = de_q && !de;

  // The first de cycle of a line is x=0; a pixel on the frame edge is y=0
  assign pix_x = de_q ? line_len : '0;
  assign pix_y = frame_edge ? '0 : y_cnt;

  // Registered copies of vs/de for edge detection; not cleared so clear
  // cannot fabricate an edge while vs is held at its active level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs;
      de_q <= de;
    end
  end

  // Line/frame counters, line-length reference and per-frame geometry latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_len   <= '0;
      y_cnt      <= '0;
      href       <= '0;
      first_done <= 1'b0;
      geom_err   <= 1'b0;
      any_de     <= 1'b0;
      last_frame <= '0;
    end else if (clear) begin
      line_len   <= '0;
      y_cnt      <= '0;
      href       <= '0;
      first_done <= 1'b0;
      geom_err   <= 1'b0;
      any_de     <= 1'b0;
      last_frame <= '0;
    end else begin
      if (de) line_len <= de_q ? line_len + 1'b1 : CNT_W'(1);

      if (frame_edge) begin
        // Close out the finished frame; a de-high edge cycle belongs to the new one
        last_frame <= '{hactive: href, vactive: y_cnt, ok: (!geom_err && any_de)};
        y_cnt      <= '0;
        href       <= '0;
        first_done <= 1'b0;
        geom_err   <= 1'b0;
        any_de     <= de;
      end else begin
        if (de) any_de <= 1'b1;
        if (de_fall) begin
          y_cnt <= y_cnt + 1'b1;
          if (!first_done) begin
            href       <= line_len;
            first_done <= 1'b1;
          end else if (line_len != href) begin
            geom_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/video_pattern_checker.sv
// Sink-side checker for the moving gray-ramp pattern: pixel compare pipeline,
// seed tracking, per-frame summary, error counting and lock detection.
module video_pattern_checker
  import video_pkg::*;
#(
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_FRAMES = 4,
  parameter int ERR_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             vs,
  input  logic             hs,
  input  logic             de,
  input  logic [7:0]       rgb_r,
  input  logic [7:0]       rgb_g,
  input  logic [7:0]       rgb_b,
  output logic [15:0]      meas_hactive,
  output logic [15:0]      meas_vactive,
  output logic [15:0]      frame_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             locked
);

  localparam int                  STREAK_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_FRAMES);

  chk_state_t       state, state_nx;
  logic             frame_edge;
  logic [CNT_W-1:0] pix_x, pix_y;
  frame_stat_t      last_frame;

  // hs carries no information the checker needs
  logic unused_hs;
  assign unused_hs = hs;

  video_timing_meas #(.VS_POL(VS_POL)) u_meas (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .vs         (vs),
    .de         (de),
    .frame_edge (frame_edge),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .last_frame (last_frame)
  );

  // ---------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: clear wins, otherwise advance only on frame edges
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else if (frame_edge) begin
      state_nx = (state == ST_IDLE) ? ST_FIRST : ST_RUN;
    end
  end

  // A pixel on the edge cycle belongs to the frame that edge opens
  logic take, seed_cap, seed_chk, seed_bad_now;
  logic [7:0] seed;
  assign take     = de && !clear && ((state != ST_IDLE) || frame_edge);
  assign seed_cap = take && (pix_x == '0) && (pix_y == '0);
  // Seed history exists if this frame is (or is about to become) a RUN frame
  assign seed_chk = frame_edge ? (state != ST_IDLE) : (state == ST_RUN);
  assign seed_bad_now = seed_cap && seed_chk && (rgb_r != seed + 8'd1);

  // ---------------------------------------------------------------- pixel pipeline
  logic             s1_vld, s2_vld, s2_err;
  logic [7:0]       s1_r, s1_g, s1_b;
  logic [CNT_W-1:0] s1_x, s1_y;
  logic             s1_origin, pix_bad, s2_hit;
  logic [7:0]       s1_exp;

  assign s1_origin = (s1_x == '0) && (s1_y == '0);
  assign s1_exp    = ramp_val(s1_x[7:0], s1_y[7:0], seed);
  // The origin pixel defines the seed, so only its gray-ness can be checked
  assign pix_bad   = (s1_g != s1_r) || (s1_b != s1_r) || (!s1_origin && (s1_r != s1_exp));
  assign s2_hit    = s2_vld && s2_err;

  // Stage 1 captures the pixel and coordinates; stage 2 registers the verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
      s1_x   <= '0;
      s1_y   <= '0;
      s2_vld <= 1'b0;
      s2_err <= 1'b0;
    end else begin
      s1_vld <= take;
      s1_r   <= rgb_r;
      s1_g   <= rgb_g;
      s1_b   <= rgb_b;
      s1_x   <= pix_x;
      s1_y   <= pix_y;
      s2_vld <= s1_vld && !clear;
      s2_err <= pix_bad;
    end
  end

  // ---------------------------------------------------------------- seed
  logic seed_err, pend_seed;

  // Seed capture at (0,0) and the +1-per-frame advance check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed      <= '0;
      seed_err  <= 1'b0;
      pend_seed <= 1'b0;
    end else if (clear) begin
      seed      <= '0;
      seed_err  <= 1'b0;
      pend_seed <= 1'b0;
    end else begin
      if (seed_cap) seed <= rgb_r;
      if (frame_edge) pend_seed <= seed_err;
      seed_err <= frame_edge ? seed_bad_now : (seed_err | seed_bad_now);
    end
  end

  // ---------------------------------------------------------------- pixel errors
  logic pix_err, pend_pix;

  // Per-frame pixel error flag (split at the edge) and saturating total
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_err  <= 1'b0;
      pend_pix <= 1'b0;
      err_cnt  <= '0;
    end else if (clear) begin
      pix_err  <= 1'b0;
      pend_pix <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (frame_edge) pend_pix <= pix_err | s2_hit;
      pix_err <= frame_edge ? 1'b0 : (pix_err | s2_hit);
      if (s2_hit && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- summary + lock
  logic [SUM_LAT-1:0]  sum_pipe;
  logic [STREAK_W-1:0] streak;
  logic                sum_start, sum_ok, geo_same;

  assign sum_start = frame_edge && (state != ST_IDLE) && !clear;
  assign sum_ok    = last_frame.ok && !pend_pix && !pend_seed;
  assign geo_same  = (last_frame.hactive == meas_hactive) &&
                     (last_frame.vactive == meas_vactive);
  assign locked    = (streak >= STREAK_MAX);

  // Publish the frame summary once the pixel pipeline has drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_pipe     <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      meas_hactive <= '0;
      meas_vactive <= '0;
      frame_cnt    <= '0;
      streak       <= '0;
    end else if (clear) begin
      sum_pipe     <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      meas_hactive <= '0;
      meas_vactive <= '0;
      frame_cnt    <= '0;
      streak       <= '0;
    end else begin
      sum_pipe   <= {sum_pipe[SUM_LAT-2:0], sum_start};
      frame_done <= sum_pipe[SUM_LAT-1];
      if (sum_pipe[SUM_LAT-1]) begin
        meas_hactive <= last_frame.hactive;
        meas_vactive <= last_frame.vactive;
        frame_ok     <= sum_ok;
        frame_cnt    <= frame_cnt + 1'b1;
        if (!sum_ok)       streak <= '0;
        else if (!geo_same) streak <= STREAK_W'(1);
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_checker.sv
// Randomized scoreboard bench for video_pattern_checker.
module tb_video_pattern_checker;

  localparam int ERR_W       = 4;
  localparam int LOCK_FRAMES = 4;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst, clear, vs, hs, de;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic [15:0] meas_hactive, meas_vactive, frame_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic frame_done, frame_ok, locked;

  video_pattern_checker #(.VS_POL(1'b1), .LOCK_FRAMES(LOCK_FRAMES), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .vs(vs), .hs(hs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .meas_hactive(meas_hactive), .meas_vactive(meas_vactive),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { int h; int v; bit ok; int fcnt; int ecnt; bit lk; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int vs_left = 0;

  // Reference model state (frame-level view of the checker)
  int m_state;               // 0 no sync yet, 1 first frame, 2 checked frames
  int m_err, m_fcnt, m_streak, m_prev_h, m_prev_v, m_seed;
  int cur_h, cur_v, cur_errs;
  bit cur_geom_bad, cur_seed_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hs = 1'($urandom_range(0, 1));
    if (vs_left > 0) begin
      vs_left--;
      if (vs_left == 0) vs = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_err = 0; m_fcnt = 0; m_streak = 0;
    m_prev_h = 0; m_prev_v = 0; m_seed = 0;
  endtask

  // A frame edge: summarise the finished frame if one was being tracked
  task automatic model_edge();
    exp_t e;
    bit same;
    if (m_state != 0) begin
      e.ok = (cur_errs == 0) && !cur_geom_bad && !cur_seed_bad;
      same = (cur_h == m_prev_h) && (cur_v == m_prev_v);
      if (!e.ok) m_streak = 0;
      else m_streak = same ? m_streak + 1 : 1;
      m_prev_h = cur_h; m_prev_v = cur_v;
      m_fcnt = (m_fcnt + 1) % 65536;
      e.h = cur_h; e.v = cur_v; e.fcnt = m_fcnt; e.ecnt = m_err;
      e.lk = (m_streak >= LOCK_FRAMES);
      exp_q.push_back(e);
    end
    m_state = (m_state == 0) ? 1 : 2;
  endtask

  // One frame: vs edge, v lines of h pixels (one line may differ), 4-cycle
  // hblank, two blank lines. Optional forced g=0xAA at (cx,cy), random
  // single-channel corruption at err_pct percent, reset pulse inside a line.
  task automatic drive_frame(input int h, input int v, input int seed,
                             input int bad_line, input int bad_len, input int err_pct,
                             input int cx, input int cy, input bit at_edge, input int rst_line);
    int len[16];
    int val, r, g, b, ex;
    bit run, bad;
    model_edge();
    run = (m_state == 2);
    cur_v = v; cur_errs = 0; cur_geom_bad = (v == 0);
    for (int l = 0; l < v; l++) begin
      len[l] = (l == bad_line) ? bad_len : h;
      if (len[l] != len[0]) cur_geom_bad = 1;
    end
    cur_h = (v > 0) ? len[0] : 0;
    cur_seed_bad = (v > 0) && run && (seed != ((m_seed + 1) % 256));
    if (v > 0) m_seed = seed;
    vs = 1'b1; vs_left = 3;
    if (!at_edge) begin de = 1'b0; repeat (3) step(); end
    for (int l = 0; l < v; l++) begin
      for (int x = 0; x < len[l]; x++) begin
        val = (x + l + seed) % 256;
        r = val; g = val; b = val;
        if (x == cx && l == cy) g = 8'hAA;
        else if (!(x == 0 && l == 0) && $urandom_range(0, 99) < err_pct) begin
          case ($urandom_range(0, 2))
            0: r = r ^ $urandom_range(1, 255);
            1: g = g ^ $urandom_range(1, 255);
            default: b = b ^ $urandom_range(1, 255);
          endcase
        end
        if (m_state != 0) begin
          ex = (x + l + seed) % 256;
          bad = (g != r) || (b != r) || (!(x == 0 && l == 0) && r != ex);
          if (bad) begin
            cur_errs++;
            if (m_err < ERR_MAX) m_err++;
          end
        end
        de = 1'b1; rgb_r = 8'(r); rgb_g = 8'(g); rgb_b = 8'(b);
        if (l == rst_line && x == 2) rst = 1'b1;
        if (l == rst_line && x == 5) begin rst = 1'b0; model_reset(); end
        step();
      end
      de = 1'b0; rgb_r = '0; rgb_g = '0; rgb_b = '0;
      repeat (4) step();
    end
    repeat (2 * (h + 4)) step();
  endtask

  task automatic clean(input int h, input int v, input int seed, input bit at_edge);
    drive_frame(h, v, seed, -1, 0, 0, -1, -1, at_edge, -1);
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
    model_reset();
    repeat (2) step();
    chk("clear_err_cnt", err_cnt, 0);
    chk("clear_frame_cnt", frame_cnt, 0);
    chk("clear_locked", locked, 0);
    chk("clear_hactive", meas_hactive, 0);
  endtask

  // Monitor: every frame_done pops one expected summary
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame_done: got frame_done=1 expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("meas_hactive", meas_hactive, e.h);
        chk("meas_vactive", meas_vactive, e.v);
        chk("frame_ok", frame_ok, e.ok);
        chk("frame_cnt", frame_cnt, e.fcnt);
        chk("err_cnt", err_cnt, e.ecnt);
        chk("locked", locked, e.lk);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0;
    rgb_r = '0; rgb_g = '0; rgb_b = '0;
    model_reset();
    cur_h = 0; cur_v = 0; cur_errs = 0; cur_geom_bad = 0; cur_seed_bad = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hactive", meas_hactive, 0);
    chk("rst_vactive", meas_vactive, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;
    repeat (4) step();

    // Reset pulse in the middle of a line
    drive_frame(8, 4, 8'h0F, -1, 0, 0, -1, -1, 1'b0, 1);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_frame_ok", frame_ok, 0);

    // Clean 8x4 stream, seed 0x10.., lock after four clean summaries
    for (int s = 8'h10; s <= 8'h15; s++) clean(8, 4, s, 1'b0);
    // Single corrupted pixel, then relock
    drive_frame(8, 4, 8'h16, -1, 0, 0, 3, 2, 1'b0, -1);
    for (int s = 8'h17; s <= 8'h1A; s++) clean(8, 4, s, 1'b0);
    // Seed skip, then a frame whose first pixel sits on the vs edge
    clean(8, 4, 8'h1C, 1'b0);
    clean(8, 4, 8'h1D, 1'b1);
    // Short line, then a new 10x4 geometry
    drive_frame(8, 4, 8'h1E, 2, 7, 0, -1, -1, 1'b0, -1);
    clean(10, 4, 8'h1F, 1'b0);
    clean(10, 4, 8'h20, 1'b0);
    // Ramp wrap across 0xFF
    clean(8, 4, 8'hFD, 1'b0);
    clean(8, 4, 8'hFE, 1'b0);
    clean(8, 4, 8'hFF, 1'b1);
    clean(8, 4, 8'h00, 1'b0);
    // Frame with no active pixels
    clean(8, 0, 0, 1'b0);
    clean(8, 4, (m_seed + 1) % 256, 1'b0);

    // Randomised frames
    for (int i = 0; i < 12; i++) begin
      int h, v, sd, bl, bln, ep;
      bit ae;
      h   = $urandom_range(4, 12);
      v   = $urandom_range(2, 5);
      sd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : (m_seed + 1) % 256;
      bl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, v - 1) : -1;
      bln = ($urandom_range(0, 1) == 0) ? h - 1 : h + 1;
      ep  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0;
      ae  = 1'($urandom_range(0, 1));
      drive_frame(h, v, sd, bl, bln, ep, -1, -1, ae, -1);
    end

    // Every non-origin pixel corrupted: counter must saturate
    drive_frame(10, 5, (m_seed + 1) % 256, -1, 0, 100, -1, -1, 1'b0, -1);
    clean(8, 4, (m_seed + 1) % 256, 1'b0);
    clean(8, 4, (m_seed + 1) % 256, 1'b0);
    do_clear();

    // Restart after clear: needs two edges before the first summary
    clean(8, 4, 8'h40, 1'b0);
    clean(8, 4, 8'h41, 1'b0);
    clean(8, 4, 8'h42, 1'b1);
    clean(8, 0, 0, 1'b0);

    repeat (20) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
